// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit between CPU and data memory
module load_store_unit #(
    parameter int MEM_ADDR_BITS = 21
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic [1:0]  rsp_cause,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_wr,
    output logic        mem_en,
    output logic [2:0]  mem_size,
    input  logic        mem_exception
);

    typedef enum logic [1:0] {IDLE, ISSUE, READ, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [2:0]  size_q;
    logic        wr_q;
    logic        exc_q;
    logic [1:0]  cause_q;
    logic        accept;
    logic [1:0]  chk_cause;

    assign accept = (state == IDLE) && req_valid;

    // Local request check: illegal size beats misalignment beats out-of-range
    always_comb begin
        chk_cause = 2'b00;
        if (req_size == 3'b011 || req_size == 3'b110 || req_size == 3'b111 ||
            (req_wr && req_size[2])) begin
            chk_cause = 2'b11;
        end else if ((req_size[1:0] == 2'b01 && req_addr[0]) ||
                     (req_size == 3'b010 && req_addr[1:0] != 2'b00)) begin
            chk_cause = 2'b01;
        end else if (req_addr[31:MEM_ADDR_BITS] != '0) begin
            chk_cause = 2'b10;
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake/memory strobes, all decoded from the current state
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    state_next = (chk_cause != 2'b00) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mem_en     = 1'b1;
                mem_wr     = wr_q;
                state_next = wr_q ? RESP : READ;
            end
            READ: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, memory exception sampling and load data capture
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            exc_q   <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        wr_q    <= req_wr;
                        exc_q   <= (chk_cause != 2'b00);
                        cause_q <= chk_cause;
                        rdata_q <= '0;
                    end
                end
                ISSUE: begin
                    if (mem_exception) begin
                        exc_q   <= 1'b1;
                        cause_q <= 2'b01;
                    end
                end
                READ: begin
                    rdata_q <= exc_q ? 32'h0 : mem_data_out;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr    = addr_q;
    assign mem_size    = size_q;
    assign mem_data_in = wdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_exc     = exc_q;
    assign rsp_cause   = cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_exc;
    logic [1:0]  rsp_cause;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out = 32'h0;
    logic        mem_wr;
    logic        mem_en;
    logic [2:0]  mem_size;
    logic        mem_exception;

    logic        inject_exc = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          en_count = 0;

    logic [7:0]  hw_mem  [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    load_store_unit #(.MEM_ADDR_BITS(21)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_exc(rsp_exc), .rsp_cause(rsp_cause),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_wr(mem_wr), .mem_en(mem_en), .mem_size(mem_size),
        .mem_exception(mem_exception)
    );

    always #5 CLK = ~CLK;

    assign mem_exception = mem_en & inject_exc;

    function automatic int nbytes(input logic [2:0] sz);
        if (sz[1:0] == 2'b00) return 1;
        if (sz[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [7:0] get_byte(input bit use_ref, input logic [31:0] a);
        if (use_ref) return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
        return hw_mem.exists(a) ? hw_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] read_ext(input bit use_ref, input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = get_byte(use_ref, a + i);
        if (!sz[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!sz[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // Behavioural data memory: sign/zero extends loads, registered read data
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_wr) begin
                if (!inject_exc)
                    for (int i = 0; i < nbytes(mem_size); i++) hw_mem[mem_addr + i] = mem_data_in[8*i +: 8];
            end else begin
                mem_data_out <= read_ext(1'b0, mem_addr, mem_size);
            end
        end
    end

    always @(posedge CLK) if (mem_en) en_count++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: decide the architectural outcome of one access
    task automatic ref_access(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic inj,
                              output logic exc, output logic [1:0] cause,
                              output logic [31:0] rdata, output int lat);
        cause = 2'b00;
        rdata = 32'h0;
        if (sz inside {3'b011, 3'b110, 3'b111} || (wr && sz inside {3'b100, 3'b101})) cause = 2'b11;
        else if ((sz inside {3'b001, 3'b101} && a % 2 != 0) || (sz == 3'b010 && a % 4 != 0)) cause = 2'b01;
        else if (a >= 32'h0020_0000) cause = 2'b10;
        if (cause != 2'b00) begin
            exc = 1'b1;
            lat = 1;
        end else begin
            lat = wr ? 2 : 3;
            exc = inj;
            if (inj) cause = 2'b01;
            else if (wr) for (int i = 0; i < nbytes(sz); i++) ref_mem[a + i] = wd[8*i +: 8];
            else rdata = read_ext(1'b1, a, sz);
        end
    endtask

    task automatic do_txn(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, input logic inj);
        logic        e_exc;
        logic [1:0]  e_cause;
        logic [31:0] e_rdata;
        int          e_lat;
        int          lat;
        int          en0;
        ref_access(wr, sz, a, wd, inj, e_exc, e_cause, e_rdata, e_lat);
        chk("req_ready_idle", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1; req_wr = wr; req_size = sz; req_addr = a; req_wdata = wd;
        inject_exc = inj;
        en0 = en_count;
        @(posedge CLK); #1;
        chk("mem_en_after_accept", {31'b0, mem_en}, (e_lat == 1) ? 32'h0 : 32'h1);
        chk("mem_addr_capture", mem_addr, a);
        req_valid = 1'($urandom_range(0, 1));
        req_addr = $urandom;
        req_wr = 1'($urandom_range(0, 1));
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("latency", lat, e_lat);
        chk("rsp_exc", {31'b0, rsp_exc}, {31'b0, e_exc});
        chk("rsp_cause", {30'b0, rsp_cause}, {30'b0, e_cause});
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("mem_en_pulses", en_count - en0, (e_lat == 1) ? 0 : 1);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(posedge CLK); #1;
            chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'h1);
            chk("hold_req_ready", {31'b0, req_ready}, 32'h0);
            chk("hold_rdata", rsp_rdata, e_rdata);
            chk("hold_exc_cause", {29'b0, rsp_exc, rsp_cause}, {29'b0, e_exc, e_cause});
            chk("hold_mem_addr", mem_addr, a);
        end
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        inject_exc = 1'b0;
        chk("released_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("released_req_ready", {31'b0, req_ready}, 32'h1);
        chk("no_extra_mem_en", en_count - en0, (e_lat == 1) ? 0 : 1);
    endtask

    initial begin
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_fields", {29'b0, rsp_exc, rsp_cause}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_strobes", {30'b0, mem_en, mem_wr}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_size_data", {29'b0, mem_size} | mem_data_in, 32'h0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK); #1;

        do_txn(1'b1, 3'b010, 32'h100, 32'h1234_5678, 0, 1'b0);
        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0);
        do_txn(1'b1, 3'b010, 32'h200, 32'h0000_00F0, 0, 1'b0);
        do_txn(1'b0, 3'b000, 32'h200, 32'h0, 0, 1'b0);
        do_txn(1'b0, 3'b100, 32'h200, 32'h0, 0, 1'b0);
        do_txn(1'b1, 3'b010, 32'h102, 32'hDEAD_BEEF, 0, 1'b0);
        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0);
        do_txn(1'b0, 3'b010, 32'h0020_0000, 32'h0, 0, 1'b0);
        do_txn(1'b1, 3'b100, 32'h104, 32'h55, 0, 1'b0);
        do_txn(1'b0, 3'b011, 32'h103, 32'h0, 0, 1'b0);
        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 5, 1'b0);
        do_txn(1'b0, 3'b001, 32'h100, 32'h0, 1, 1'b1);
        do_txn(1'b1, 3'b001, 32'h100, 32'hAAAA_BBBB, 0, 1'b1);

        // Reset while the load sits in READ
        req_valid = 1'b1; req_wr = 1'b0; req_size = 3'b010; req_addr = 32'h100;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        chk("midrst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("midrst_strobes", {29'b0, mem_en, mem_wr, rsp_valid}, 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            chk("postrst_no_rsp", {31'b0, rsp_valid}, 32'h0);
        end
        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 32'h0020_0000 | ($urandom & 32'hFFE0_0000);
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                   $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
